uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter, the transmit-side counterpart of the UART receiver in the UART block. Accepts a parallel byte with a single-cycle valid strobe and serializes it onto TX_OUT as start bit, DATA_WIDTH data bits LSB first, optional parity bit, and stop bit. clk runs at the baud rate, supplied by the system clock divider, so one clk cycle equals one bit period. Busy tells the upstream controller (register file / FIFO reader) when a new byte may be offered.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (1..16).

Ports:
clk  input  1  baud-rate clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous and active-low.
P_DATA  input  DATA_WIDTH  parallel byte to send; sampled only on acceptance.
Data_Valid  input  1  offer strobe; accepted only in IDLE.
PAR_EN  input  1  1 = include parity bit; sampled on acceptance.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
TX_OUT  output  1  serial line; idles high.
Busy  output  1  high from acceptance until end of stop bit.

Behaviour:
- Reset (rst low, async): state = IDLE, TX_OUT = 1, Busy = 0, bit counter = 0, shift/holding registers = 0. Release is synchronous to the next clk edge.
- TX_OUT and Busy are registered outputs. No combinational path from any input to any output.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT = 1, Busy = 0. Rising edge with Data_Valid = 1:
  - latch P_DATA into the shift register; latch PAR_EN and PAR_TYP.
  - compute parity bit = XOR(P_DATA) XOR PAR_TYP.
  - go to START; TX_OUT = 0 and Busy = 1 from that edge.
- START: one cycle, then DATA with TX_OUT = latched bit 0.
- DATA: DATA_WIDTH cycles, LSB first. Counter runs 0..DATA_WIDTH-1.
  - At count DATA_WIDTH-1: go to PARITY if latched PAR_EN = 1, else STOP.
- PARITY: one cycle, TX_OUT = latched parity bit, then STOP.
- STOP: one cycle, TX_OUT = 1. At its ending edge go to IDLE and Busy = 0.
- Frame length: DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
- Minimum spacing between acceptances: frame length + 1 cycle, because Data_Valid is accepted only in IDLE.
- Data_Valid while Busy = 1 is ignored. The byte is dropped, with no queueing and no effect on the current frame.
- Changes to P_DATA, PAR_EN or PAR_TYP after acceptance do not affect the frame in flight.
- Reset mid-frame: line returns high immediately (async), frame is abandoned, and no partial frame resumes after release.
- Parity is computed on the latched data, never on the live P_DATA.

Decomposition:
- Shared package uart_pkg:
  - state encoding enum (IDLE, START, DATA, PARITY, STOP), also reused by the RX FSM for consistency;
  - constants PAR_EVEN = 0 and PAR_ODD = 1;
  - helper function for the counter width, $clog2(DATA_WIDTH).
- One natural sub-module, uart_tx_serializer:
  - load/shift register plus bit counter with a ser_done flag;
  - the FSM and output mux stay in uart_tx.

Test Plan:
- P_DATA=0xA5, PAR_EN=0, 1-cycle Data_Valid -> TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1; Busy high exactly those 10 cycles, then TX_OUT=1, Busy=0.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 (even) -> 11-bit frame, parity bit 0 (four ones). Same byte with PAR_TYP=1 -> parity bit 1.
- P_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> data bits all 0, parity 1, stop 1; P_DATA=0xFF even -> parity 0.
- Data_Valid with 0x3C pulsed at cycles 3 and 7 of a frame sending 0x81 -> 0x81 frame intact, 0x3C never sent. Same byte offered after Busy falls -> sent correctly.
- P_DATA switched from 0x55 to 0xAA one cycle after acceptance -> line carries 0x55 bits.
- rst asserted during data bit 4 -> TX_OUT=1 and Busy=0 asynchronously. After release the line stays idle until a new Data_Valid, and the next frame is complete and correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding, parity constants and helpers
// used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Bit-counter width; a 1-bit frame still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Callers zero-extend narrower words, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [15:0] data, input logic par_typ);
    return (^data) ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame datapath: holds the accepted word, shifts it out LSB first and counts
// data bits, flagging the last one with ser_done.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  cnt_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int              CW       = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_r;
  logic [CW-1:0]         cnt_r;

  // shift register: load on acceptance, shift once per bit entering DATA
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= '0;
    end else if (load) begin
      shift_r <= load_data;
    end else if (shift) begin
      shift_r <= shift_r >> 1'b1;
    end else begin
      shift_r <= shift_r;
    end
  end

  // data-bit counter, cleared on load and after the last bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (load || ser_done) begin
      cnt_r <= '0;
    end else if (cnt_en) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign ser_bit  = shift_r[0];
  assign ser_done = cnt_en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one clk per bit; start, LSB-first data, optional parity, stop.
// TX_OUT and Busy are registered from the next-state decode so they change on the same edge as the state.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  uart_state_e state_r, next_state_s;
  logic tx_r, busy_r, tx_next_s, busy_next_s;
  logic par_en_r, par_bit_r;
  logic accept_s, shift_s, cnt_en_s, ser_bit_s, ser_done_s;

  assign accept_s = (state_r == ST_IDLE) && Data_Valid;
  assign shift_s  = (next_state_s == ST_DATA);
  assign cnt_en_s = (state_r == ST_DATA);

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (accept_s),
    .shift     (shift_s),
    .cnt_en    (cnt_en_s),
    .load_data (P_DATA),
    .ser_bit   (ser_bit_s),
    .ser_done  (ser_done_s)
  );

  // frame options captured at acceptance; parity from the captured word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
    end else if (accept_s) begin
      par_en_r  <= PAR_EN;
      par_bit_r <= calc_parity(16'(P_DATA), PAR_TYP);
    end else begin
      par_en_r  <= par_en_r;
      par_bit_r <= par_bit_r;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state decode
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (Data_Valid) next_state_s = ST_START;
        else            next_state_s = ST_IDLE;
      end
      ST_START:  next_state_s = ST_DATA;
      ST_DATA: begin
        if (!ser_done_s)   next_state_s = ST_DATA;
        else if (par_en_r) next_state_s = ST_PARITY;
        else               next_state_s = ST_STOP;
      end
      ST_PARITY: next_state_s = ST_STOP;
      ST_STOP:   next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // line value and busy flag for the state being entered
  always_comb begin
    tx_next_s   = 1'b1;
    busy_next_s = 1'b1;
    case (next_state_s)
      ST_IDLE: begin
        tx_next_s   = 1'b1;
        busy_next_s = 1'b0;
      end
      ST_START:  tx_next_s = 1'b0;
      ST_DATA:   tx_next_s = ser_bit_s;
      ST_PARITY: tx_next_s = par_bit_r;
      ST_STOP:   tx_next_s = 1'b1;
      default: begin
        tx_next_s   = 1'b1;
        busy_next_s = 1'b0;
      end
    endcase
  end

  // output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      tx_r   <= tx_next_s;
      busy_r <= busy_next_s;
    end
  end

  assign TX_OUT = tx_r;
  assign Busy   = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: frames are given as hand-built bit
// vectors, bit i being the line value in frame cycle i.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one word, then walk the frame on negedges. dv1/dv2: frame cycles in
  // which to pulse Data_Valid with alt; sw: switch P_DATA to alt right after acceptance.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic pen,
                           input logic ptyp, input logic [10:0] exp_bits, input int len,
                           input int dv1, input int dv2, input logic [7:0] alt,
                           input logic sw);
    @(negedge clk);
    P_DATA     = data;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
    if (sw) begin
      P_DATA  = alt;
      PAR_EN  = ~pen;
      PAR_TYP = ~ptyp;
    end
    for (int i = 0; i < len; i++) begin
      check_val($sformatf("%s_tx%0d", tag, i), {31'd0, TX_OUT}, {31'd0, exp_bits[i]});
      check_val($sformatf("%s_busy%0d", tag, i), {31'd0, Busy}, 32'd1);
      if (i == dv1 || i == dv2) begin
        P_DATA     = alt;
        Data_Valid = 1'b1;
      end else begin
        Data_Valid = 1'b0;
      end
      @(negedge clk);
    end
    Data_Valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("%s_idle_tx%0d", tag, k), {31'd0, TX_OUT}, 32'd1);
      check_val($sformatf("%s_idle_busy%0d", tag, k), {31'd0, Busy}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b0;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    #12;
    check_val("reset_tx", {31'd0, TX_OUT}, 32'd1);
    check_val("reset_busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("post_reset_tx", {31'd0, TX_OUT}, 32'd1);

    // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1
    run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 11'b0_1_10100101_0, 10, -1, -1, 8'h00, 1'b0);
    // 0xA5 has four ones: even parity 0, odd parity 1
    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 11'b1_0_10100101_0, 11, -1, -1, 8'h00, 1'b0);
    run_frame("a5_odd",  8'hA5, 1'b1, 1'b1, 11'b1_1_10100101_0, 11, -1, -1, 8'h00, 1'b0);
    run_frame("00_odd",  8'h00, 1'b1, 1'b1, 11'b1_1_00000000_0, 11, -1, -1, 8'h00, 1'b0);
    run_frame("ff_even", 8'hFF, 1'b1, 1'b0, 11'b1_0_11111111_0, 11, -1, -1, 8'h00, 1'b0);

    // 0x3C offered twice while busy with 0x81: dropped, then sent once idle
    run_frame("81_busy", 8'h81, 1'b0, 1'b0, 11'b0_1_10000001_0, 10, 3, 7, 8'h3C, 1'b0);
    run_frame("3c_after", 8'h3C, 1'b0, 1'b0, 11'b0_1_00111100_0, 10, -1, -1, 8'h00, 1'b0);

    // inputs changed after acceptance must not disturb the frame
    run_frame("55_switch", 8'h55, 1'b0, 1'b0, 11'b0_1_01010101_0, 10, -1, -1, 8'hAA, 1'b1);

    // reset during data bit 4 of 0xC3 (frame cycle 5)
    @(negedge clk);
    P_DATA     = 8'hC3;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
    repeat (5) @(negedge clk);
    check_val("c3_bit4_tx", {31'd0, TX_OUT}, 32'd0);
    check_val("c3_bit4_busy", {31'd0, Busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("midrst_tx", {31'd0, TX_OUT}, 32'd1);
    check_val("midrst_busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_val($sformatf("rel_idle_tx%0d", i), {31'd0, TX_OUT}, 32'd1);
      check_val($sformatf("rel_idle_busy%0d", i), {31'd0, Busy}, 32'd0);
    end
    run_frame("c3_after_rst", 8'hC3, 1'b0, 1'b0, 11'b0_1_11000011_0, 10, -1, -1, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
